// File: rtl/instruction_sequencer.sv
// Multi-cycle instruction sequencer: one-hot enables held for STEPS cycles.
// Optional macro SEQUENCER_ILLEGAL_TRAP_EN makes illegal opcodes trap until reset.
module instruction_sequencer #(
  parameter int OPW = 4,
  parameter int STEPS = 3,
  parameter logic [2**OPW-1:0] VALID_MASK = 16'h93DF
) (
  input  logic                 Clock,
  input  logic                 Resetn,
  input  logic                 Run,
  input  logic [OPW-1:0]       Instr,
  output logic                 Ready,
  output logic [2**OPW-1:0]    En,
  output logic [(STEPS>1 ? $clog2(STEPS) : 1)-1:0] Step,
  output logic                 Busy,
  output logic                 Done,
  output logic                 Illegal
);

  localparam int EW = 2**OPW;
  localparam int SW = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [SW-1:0] LAST = SW'(STEPS - 1);
  localparam logic [SW-1:0] PENULT = SW'(STEPS - 2);

`ifdef SEQUENCER_ILLEGAL_TRAP_EN
  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_TRAP
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC
  } state_t;
`endif

  state_t          state_q;
  logic [EW-1:0]   en_q;
  logic [SW-1:0]   step_q;
  logic            busy_q;
  logic            done_q;
  logic            ill_q;

  logic            last_step;
  logic            accept;
  logic            legal;

  // Ready depends only on registered state, never on Run/Instr.
  assign last_step = (state_q == S_EXEC) && (step_q == LAST);
  assign Ready     = (state_q == S_IDLE) || last_step;
  assign accept    = Run && Ready;
  assign legal     = VALID_MASK[Instr];

  // Sequencer FSM with registered outputs.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q <= S_IDLE;
      en_q    <= '0;
      step_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      unique case (state_q)
`ifdef SEQUENCER_ILLEGAL_TRAP_EN
        S_TRAP: begin
          ill_q <= 1'b1;
        end
`endif
        default: begin
          if (accept && legal) begin
            state_q <= S_EXEC;
            en_q    <= EW'(1) << Instr;
            step_q  <= '0;
            busy_q  <= 1'b1;
            done_q  <= (STEPS == 1);
            ill_q   <= 1'b0;
          end else if (accept) begin
`ifdef SEQUENCER_ILLEGAL_TRAP_EN
            state_q <= S_TRAP;
`else
            state_q <= S_IDLE;
`endif
            en_q    <= '0;
            step_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ill_q   <= 1'b1;
          end else if (state_q == S_EXEC && !last_step) begin
            step_q  <= step_q + SW'(1);
            done_q  <= (step_q == PENULT);
            ill_q   <= 1'b0;
          end else begin
            state_q <= S_IDLE;
            en_q    <= '0;
            step_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ill_q   <= 1'b0;
          end
        end
      endcase
    end
  end

  assign En      = en_q;
  assign Step    = step_q;
  assign Busy    = busy_q;
  assign Done    = done_q;
  assign Illegal = ill_q;

endmodule

// File: doc/instruction_sequencer.md
INSTRUCTION_SEQUENCER -- requirements
Module: instruction_sequencer

Interface
REQ-001 SHALL have parameter OPW, default 4, meaning opcode width in bits (legal 2..6).
REQ-002 SHALL have parameter STEPS, default 3, meaning execute cycles per legal instruction (legal 1..16).
REQ-003 SHALL have parameter VALID_MASK, width 2**OPW, default 16'h93DF (opcodes 0,1,2,3,4,6,7,8,9,12,15 legal), meaning bit k=1 marks opcode k legal.
REQ-004 SHALL have port Clock  input  1  rising-edge clock, single clock domain.
REQ-005 SHALL have port Resetn  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port Run  input  1  instruction-valid request.
REQ-007 SHALL have port Instr  input  OPW  opcode, sampled only on accept.
REQ-008 SHALL have port Ready  output  1  block can accept an instruction this cycle.
REQ-009 SHALL have port En  output  2**OPW  one-hot control enables, bit k for opcode k.
REQ-010 SHALL have port Step  output  clog2(STEPS) (min 1)  current execute step (T-state) index.
REQ-011 SHALL have port Busy  output  1  high while executing.
REQ-012 SHALL have port Done  output  1  one-cycle pulse on final execute step.
REQ-013 SHALL have port Illegal  output  1  illegal-opcode indication.

Function
REQ-014 SHALL implement states IDLE, EXEC, and TRAP (TRAP only with REQ-028 macro).
REQ-015 SHALL define accept as Run=1 and Ready=1 at a rising Clock edge; Run while Ready=0 SHALL be ignored with no side effect.
REQ-016 SHALL drive Ready=1 in IDLE and on the final EXEC step (Step=STEPS-1); Ready=0 otherwise.
REQ-017 On accept of a legal opcode k, SHALL enter EXEC next cycle with Step=0, Busy=1, En=one-hot(k), held unchanged for exactly STEPS cycles.
REQ-018 SHALL increment Step by 1 per cycle in EXEC; Step SHALL never exceed STEPS-1 and SHALL read 0 outside EXEC.
REQ-019 SHALL assert Done=1 only in the cycle where Step=STEPS-1; with STEPS=1 Done SHALL be high in the single EXEC cycle.
REQ-020 Accept on final step (back-to-back) SHALL enter EXEC step 0 with the new opcode next cycle, no IDLE gap, Busy staying 1.
REQ-021 With no accept on final step, SHALL return to IDLE next cycle with En=0, Busy=0.
REQ-022 En SHALL be all-zero whenever not in EXEC, and SHALL be exactly one-hot in EXEC.
REQ-023 On accept of an opcode with VALID_MASK bit 0, SHALL NOT enter EXEC; En SHALL stay 0 and Illegal SHALL pulse for one cycle following accept.
REQ-024 All outputs except Ready SHALL be registered; Ready SHALL be decoded from registered state only (no combinational path from Run or Instr).

Reset
REQ-025 When Resetn=0 at a rising edge, SHALL enter IDLE with En=0, Step=0, Busy=0, Done=0, Illegal=0, from any state including mid-EXEC and TRAP.
REQ-026 Ready SHALL be 1 in the first cycle after the reset edge; a Run presented in the same cycle as Resetn=0 SHALL be discarded.
REQ-027 No instruction in progress at reset SHALL complete or produce Done.

Configuration
REQ-028 Macro SEQUENCER_ILLEGAL_TRAP_EN defined: illegal accept SHALL enter TRAP; Illegal SHALL stay 1 and Ready 0 until Resetn=0.
REQ-029 Macro SEQUENCER_ILLEGAL_TRAP_EN undefined: illegal accept SHALL pulse Illegal one cycle, state stays IDLE, Ready stays 1; TRAP logic SHALL be absent.

Verification
REQ-030 Defaults, reset, Run=1 Instr=4'h6 one cycle -> next 3 cycles En=16'h0040, Step=0,1,2, Done=1 on Step=2 only, then En=0, Busy=0.
REQ-031 Instr=4'h2 accepted, Run=1 Instr=4'hF held on final step -> cycle after Done, En=16'h8000 Step=0, no idle gap.
REQ-032 Instr=4'h5 (illegal) without macro -> Illegal=1 one cycle, En=0, Ready=1 throughout; with macro -> Illegal=1, Ready=0 persistent until Resetn=0.
REQ-033 Instr=4'h9 accepted, Resetn=0 at Step=1 -> next cycle all outputs 0, Ready=1, no Done observed.
REQ-034 Run=1 Instr=4'h0 at Step=0 and Step=1 of an EXEC -> ignored, current En unchanged, no extra instruction executed.
REQ-035 OPW=3, STEPS=1, VALID_MASK=8'hFF, opcodes 0..7 back-to-back -> En=8'h01..8'h80 consecutive cycles, Done=1 every cycle, Busy=1 continuously.
